mem_arbiter: RTL

Shared main-memory arbiter and burst sequencer for the RV32I core's instruction-cache and data-cache line transfers. It sits between the two caches' miss/refill ports and the single main-memory port, behind the cache-side `miss` stall. It grants one requester at a time and issues a fixed-length line burst, one word per memory handshake. It returns read data, or pulls write data, beat by beat, then signals completion.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: FSM state codes, owner encoding and
// the line-offset width helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Byte-offset bits inside one line: word index bits plus the 2 byte bits.
  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/refill ports and the main-memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory view.
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_done;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_wnext;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_done,
    output d_wnext, d_gnt, d_rvalid, d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_done,
    input  d_wnext, d_gnt, d_rvalid, d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational owner selection between the ICache and DCache requests.
// MEM_ARB_RR_EN: ties go to the requester that was not the last owner.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic owner
);

  // Tie-break first, then single-requester cases.
  always_comb begin
    owner = OWN_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      owner = ~last_owner;
`else
      owner = OWN_D;
`endif
    end else if (d_req) begin
      owner = OWN_D;
    end else begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Line-burst arbiter sharing one memory port between ICache and DCache.
// Define MEM_ARB_RR_EN for round-robin ties; default is DCache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int              OFF       = off_bits(LINE_WORDS);
  localparam int              BW        = OFF - 2;
  localparam logic [31:0]     LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [BW-1:0]   BEAT_LAST = BW'(LINE_WORDS - 1);
  localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic          owner;
  logic          we;
  logic [31:0]   base;
  logic [31:0]   mem_addr_q;
  logic          i_rvalid_q;
  logic          d_rvalid_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;

  logic          pick_owner;
  logic          any_req;
  logic          acked;
  logic [31:0]   req_addr;
  logic [31:0]   next_addr;

  assign any_req   = bus.i_req | bus.d_req;
  assign req_addr  = (pick_owner == OWN_D) ? bus.d_addr : bus.i_addr;
  assign acked     = (state == ST_BURST) & bus.mem_ack;
  // Beat counter wraps inside the line, so the address never leaves it.
  assign next_addr = base | 32'({beat + BEAT_ONE, 2'b00});

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // Remember who was granted most recently for the round-robin tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_I;
    end else if (state == ST_IDLE && any_req) begin
      last_owner <= pick_owner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .owner      (pick_owner)
  );

  // Burst FSM, beat counter, beat address and refill data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat       <= {BW{1'b0}};
      owner      <= OWN_I;
      we         <= 1'b0;
      base       <= 32'h0000_0000;
      mem_addr_q <= 32'h0000_0000;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state      <= ST_BURST;
            owner      <= pick_owner;
            we         <= (pick_owner == OWN_D) & bus.d_we;
            base       <= req_addr & ~LINE_MASK;
            mem_addr_q <= req_addr & ~LINE_MASK;
            beat       <= {BW{1'b0}};
          end
        end
        ST_BURST: begin
          if (bus.mem_ack) begin
            beat       <= beat + BEAT_ONE;
            mem_addr_q <= next_addr;
            if (!we) begin
              if (owner == OWN_D) begin
                d_rvalid_q <= 1'b1;
                d_rdata_q  <= bus.mem_rdata;
              end else begin
                i_rvalid_q <= 1'b1;
                i_rdata_q  <= bus.mem_rdata;
              end
            end
            if (beat == BEAT_LAST) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = (state == ST_BURST);
  assign bus.mem_we    = (state == ST_BURST) & we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.d_wnext   = acked & we;

  assign bus.i_gnt     = (state != ST_IDLE) & (owner == OWN_I);
  assign bus.d_gnt     = (state != ST_IDLE) & (owner == OWN_D);
  assign bus.i_done    = (state == ST_DONE) & (owner == OWN_I);
  assign bus.d_done    = (state == ST_DONE) & (owner == OWN_D);

  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
